// File: rtl/vga_timing_decoder.sv
// vga_timing_decoder: receive-side VGA timing recovery.
// Registers incoming HS/VS/BLANK/RGB, measures line and frame geometry,
// locks after LOCK_FRAMES identical frames and emits pixels with X/Y.
// Optional statistics counters are enabled with `define VGA_DEC_STATS_EN.
module vga_timing_decoder #(
  parameter int unsigned LOCK_FRAMES = 2,
  parameter int unsigned TIMEOUT     = 4096
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iVGA_HS,
  input  logic        iVGA_VS,
  input  logic        iVGA_BLANK,
  input  logic [9:0]  iVGA_R,
  input  logic [9:0]  iVGA_G,
  input  logic [9:0]  iVGA_B,
  output logic [9:0]  oPix_R,
  output logic [9:0]  oPix_G,
  output logic [9:0]  oPix_B,
  output logic        oPix_Valid,
  output logic [10:0] oPix_X,
  output logic [10:0] oPix_Y,
  output logic        oSOF,
  output logic        oEOL,
  output logic [11:0] oH_Total,
  output logic [11:0] oH_Act,
  output logic [11:0] oV_Total,
  output logic [11:0] oV_Act,
  output logic        oLocked,
  output logic        oErr,
  output logic [15:0] oFrame_Cnt,
  output logic [7:0]  oErr_Cnt
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT);
  localparam logic [TW-1:0] TO_FIRE = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_VERIFY  = 2'd2,
    ST_LOCKED  = 2'd3
  } state_t;

  // input stage and one-cycle-older copy for edge detection
  logic        s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d, s1_blank_q, s1_blank_d;
  logic [9:0]  s1_r_q, s1_r_d, s1_g_q, s1_g_d, s1_b_q, s1_b_d;
  logic        prev_hs_q, prev_hs_d, prev_vs_q, prev_vs_d, prev_blank_q, prev_blank_d;

  // measurement
  logic [11:0] h_cnt_q, h_cnt_d, h_act_cnt_q, h_act_cnt_d;
  logic [11:0] v_cnt_q, v_cnt_d, v_act_cnt_q, v_act_cnt_d;
  logic [11:0] h_tot_line_q, h_tot_line_d, h_act_line_q, h_act_line_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;

  // stored geometry
  logic [11:0] h_tot_s_q, h_tot_s_d, h_act_s_q, h_act_s_d;
  logic [11:0] v_tot_s_q, v_tot_s_d, v_act_s_q, v_act_s_d;

  // control
  state_t      state_q, state_d;
  logic [3:0]  match_q, match_d;
  logic        err_q, err_d;

  // pixel output stage
  logic [9:0]  pix_r_q, pix_r_d, pix_g_q, pix_g_d, pix_b_q, pix_b_d;
  logic        pix_valid_q, pix_valid_d, sof_q, sof_d, eol_q, eol_d;
  logic [10:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;

  // combinational helpers
  logic        hs_fall, vs_fall, blank_rise, blank_fall;
  logic        h_sat, line_has_act, to_hit, geo_match, store, line_err, frame_err;
  logic [11:0] h_meas, v_meas, v_act_meas;
  logic [3:0]  new_match;

  // input registration and edge detection on the registered copy
  always_comb begin
    s1_hs_d      = iVGA_HS;
    s1_vs_d      = iVGA_VS;
    s1_blank_d   = iVGA_BLANK;
    s1_r_d       = iVGA_R;
    s1_g_d       = iVGA_G;
    s1_b_d       = iVGA_B;
    prev_hs_d    = s1_hs_q;
    prev_vs_d    = s1_vs_q;
    prev_blank_d = s1_blank_q;
    hs_fall      = prev_hs_q & ~s1_hs_q;
    vs_fall      = prev_vs_q & ~s1_vs_q;
    blank_rise   = ~prev_blank_q & s1_blank_q;
    blank_fall   = prev_blank_q & ~s1_blank_q;
  end

  // line/frame measurement counters and sync timeout
  always_comb begin
    h_sat        = (h_cnt_q == '1);
    h_meas       = h_cnt_q + 12'd1;
    h_cnt_d      = hs_fall ? '0 : (h_sat ? h_cnt_q : h_cnt_q + 12'd1);
    h_act_cnt_d  = h_act_cnt_q;
    if (hs_fall) begin
      h_act_cnt_d = {11'd0, s1_blank_q};
    end else if (s1_blank_q && (h_act_cnt_q != '1)) begin
      h_act_cnt_d = h_act_cnt_q + 12'd1;
    end
    line_has_act = hs_fall && (h_act_cnt_q != '0);
    h_tot_line_d = hs_fall ? h_meas : h_tot_line_q;
    h_act_line_d = line_has_act ? h_act_cnt_q : h_act_line_q;
    // frame totals include an HS fall landing in the same cycle as the VS fall
    v_meas       = v_cnt_q + {11'd0, hs_fall && (v_cnt_q != '1)};
    v_act_meas   = v_act_cnt_q + {11'd0, line_has_act && (v_act_cnt_q != '1)};
    v_cnt_d      = vs_fall ? '0 : v_meas;
    v_act_cnt_d  = vs_fall ? '0 : v_act_meas;
    to_hit       = !hs_fall && (to_cnt_q >= TO_FIRE);
    to_cnt_d     = hs_fall ? '0 : ((to_cnt_q >= TO_MAX) ? to_cnt_q : to_cnt_q + 1'b1);
  end

  // lock FSM: next state, match count, geometry store and error pulse
  always_comb begin
    state_d   = state_q;
    match_d   = match_q;
    store     = 1'b0;
    err_d     = 1'b0;
    geo_match = (h_tot_line_d == h_tot_s_q) && (h_act_line_d == h_act_s_q) &&
                (v_meas == v_tot_s_q) && (v_act_meas == v_act_s_q);
    new_match = geo_match ? match_q + 4'd1 : 4'd1;
    line_err  = hs_fall && (h_sat || (h_meas != h_tot_s_q) ||
                ((h_act_cnt_q != '0) && (h_act_cnt_q != h_act_s_q)));
    frame_err = vs_fall && ((v_meas != v_tot_s_q) || (v_act_meas != v_act_s_q));
    if (to_hit) begin
      // a stuck HS keeps the FSM parked in SEARCH; only the entry reports an error
      state_d = ST_SEARCH;
      match_d = '0;
      err_d   = (state_q != ST_SEARCH);
    end else begin
      unique case (state_q)
        ST_SEARCH: begin
          if (vs_fall) state_d = ST_MEASURE;
        end
        ST_MEASURE: begin
          if (vs_fall) begin
            store   = 1'b1;
            match_d = 4'd1;
            state_d = (LOCK_FRAMES <= 1) ? ST_LOCKED : ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (vs_fall) begin
            store   = !geo_match;
            match_d = new_match;
            if ({28'd0, new_match} >= LOCK_FRAMES) state_d = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (line_err || frame_err) begin
            state_d = ST_SEARCH;
            match_d = '0;
            err_d   = 1'b1;
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end
    h_tot_s_d = store ? h_tot_line_d : h_tot_s_q;
    h_act_s_d = store ? h_act_line_d : h_act_s_q;
    v_tot_s_d = store ? v_meas       : v_tot_s_q;
    v_act_s_d = store ? v_act_meas   : v_act_s_q;
  end

  // pixel output stage with recovered coordinates
  always_comb begin
    pix_r_d     = s1_r_q;
    pix_g_d     = s1_g_q;
    pix_b_d     = s1_b_q;
    // gating on the next state drops valid in the same cycle oLocked falls
    pix_valid_d = s1_blank_q && (state_d == ST_LOCKED);
    pix_x_d     = pix_x_q;
    if (blank_rise)      pix_x_d = '0;
    else if (s1_blank_q) pix_x_d = pix_x_q + 11'd1;
    pix_y_d     = pix_y_q;
    if (vs_fall)         pix_y_d = '0;
    else if (blank_fall) pix_y_d = pix_y_q + 11'd1;
    sof_d       = pix_valid_d && (pix_x_d == '0) && (pix_y_d == '0);
    eol_d       = pix_valid_d && (({1'b0, pix_x_d} + 12'd1) == h_act_s_q);
  end

  // state register for all datapath and control flops
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      s1_hs_q      <= 1'b0;
      s1_vs_q      <= 1'b0;
      s1_blank_q   <= 1'b0;
      s1_r_q       <= '0;
      s1_g_q       <= '0;
      s1_b_q       <= '0;
      prev_hs_q    <= 1'b0;
      prev_vs_q    <= 1'b0;
      prev_blank_q <= 1'b0;
      h_cnt_q      <= '0;
      h_act_cnt_q  <= '0;
      v_cnt_q      <= '0;
      v_act_cnt_q  <= '0;
      h_tot_line_q <= '0;
      h_act_line_q <= '0;
      to_cnt_q     <= '0;
      h_tot_s_q    <= '0;
      h_act_s_q    <= '0;
      v_tot_s_q    <= '0;
      v_act_s_q    <= '0;
      state_q      <= ST_SEARCH;
      match_q      <= '0;
      err_q        <= 1'b0;
      pix_r_q      <= '0;
      pix_g_q      <= '0;
      pix_b_q      <= '0;
      pix_valid_q  <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      sof_q        <= 1'b0;
      eol_q        <= 1'b0;
    end else begin
      s1_hs_q      <= s1_hs_d;
      s1_vs_q      <= s1_vs_d;
      s1_blank_q   <= s1_blank_d;
      s1_r_q       <= s1_r_d;
      s1_g_q       <= s1_g_d;
      s1_b_q       <= s1_b_d;
      prev_hs_q    <= prev_hs_d;
      prev_vs_q    <= prev_vs_d;
      prev_blank_q <= prev_blank_d;
      h_cnt_q      <= h_cnt_d;
      h_act_cnt_q  <= h_act_cnt_d;
      v_cnt_q      <= v_cnt_d;
      v_act_cnt_q  <= v_act_cnt_d;
      h_tot_line_q <= h_tot_line_d;
      h_act_line_q <= h_act_line_d;
      to_cnt_q     <= to_cnt_d;
      h_tot_s_q    <= h_tot_s_d;
      h_act_s_q    <= h_act_s_d;
      v_tot_s_q    <= v_tot_s_d;
      v_act_s_q    <= v_act_s_d;
      state_q      <= state_d;
      match_q      <= match_d;
      err_q        <= err_d;
      pix_r_q      <= pix_r_d;
      pix_g_q      <= pix_g_d;
      pix_b_q      <= pix_b_d;
      pix_valid_q  <= pix_valid_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      sof_q        <= sof_d;
      eol_q        <= eol_d;
    end
  end

`ifdef VGA_DEC_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  // locked-frame counter (wrapping) and error counter (saturating)
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (vs_fall && (state_q == ST_LOCKED)) frame_cnt_d = frame_cnt_q + 16'd1;
    if (err_d && (err_cnt_q != '1))        err_cnt_d   = err_cnt_q + 8'd1;
  end

  // statistics registers
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign oFrame_Cnt = frame_cnt_q;
  assign oErr_Cnt   = err_cnt_q;
`else
  assign oFrame_Cnt = '0;
  assign oErr_Cnt   = '0;
`endif

  assign oPix_R     = pix_r_q;
  assign oPix_G     = pix_g_q;
  assign oPix_B     = pix_b_q;
  assign oPix_Valid = pix_valid_q;
  assign oPix_X     = pix_x_q;
  assign oPix_Y     = pix_y_q;
  assign oSOF       = sof_q;
  assign oEOL       = eol_q;
  assign oH_Total   = h_tot_s_q;
  assign oH_Act     = h_act_s_q;
  assign oV_Total   = v_tot_s_q;
  assign oV_Act     = v_act_s_q;
  assign oLocked    = (state_q == ST_LOCKED);
  assign oErr       = err_q;

endmodule
